// File: rtl/calc_alu_seg_if.sv
// Keypad/switch inputs and 7-segment outputs of the calculator core.
// master = switch/key side driving operands and op, slave = calc_alu_seg.
interface calc_alu_seg_if;
    logic [3:0] in_number;   // operand value, true polarity
    logic [3:0] arif;        // op select, active-low one-hot
    logic [1:0] key;         // record keys, active-low
    logic [3:0] anodes;      // digit enables, active-low, [0]=rightmost
    logic [7:0] segments;    // active-low, [7]=dp, [6:0]=g..a

    modport master (
        output in_number,
        output arif,
        output key,
        input  anodes,
        input  segments
    );

    modport slave (
        input  in_number,
        input  arif,
        input  key,
        output anodes,
        output segments
    );
endinterface

// File: rtl/calc_alu_seg.sv
// Arithmetic core and 4-digit multiplexed 7-segment driver of the switch
// calculator. Two 4-bit operands are latched from push keys, the op selected
// on arif is applied, and the signed decimal result is scanned out on a
// common-anode display.
// Optional feature macro: CALC_LZB_EN blanks leading-zero hundreds/tens digits.
module calc_alu_seg #(
    parameter int SCAN_BITS = 16,
    parameter int DATA_W    = 4
) (
    input  logic           clk,
    input  logic           rst,
    calc_alu_seg_if.slave  bus
);

    localparam int RES_W = 9;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;

    typedef enum logic [1:0] {
        MODE_NUM  = 2'd0,
        MODE_ERR  = 2'd1,
        MODE_DASH = 2'd2
    } mode_t;

    // Binary (0..255) to three packed BCD digits by shift-and-add-3.
    function automatic logic [11:0] to_bcd(input logic [7:0] v);
        logic [11:0] bcd;
        bcd = '0;
        for (int i = 7; i >= 0; i--) begin
            if (bcd[3:0]  >= 4'd5) bcd[3:0]  = bcd[3:0]  + 4'd3;
            if (bcd[7:4]  >= 4'd5) bcd[7:4]  = bcd[7:4]  + 4'd3;
            if (bcd[11:8] >= 4'd5) bcd[11:8] = bcd[11:8] + 4'd3;
            bcd = {bcd[10:0], v[i]};
        end
        return bcd;
    endfunction

    // Decimal digit to active-low g..a pattern; out-of-range shows blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // ---------------- stage p0: operand registers ----------------
    logic [DATA_W-1:0] a_p0;
    logic [DATA_W-1:0] b_p0;
    logic              last_b_p0;   // 0: last key was A, 1: last key was B

    // Level-sampled record keys; both or neither pressed leaves operands alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_p0      <= '0;
            b_p0      <= '0;
            last_b_p0 <= 1'b0;
        end else begin
            case (bus.key)
                2'b10: begin
                    a_p0      <= bus.in_number;
                    last_b_p0 <= 1'b0;
                end
                2'b01: begin
                    b_p0      <= bus.in_number;
                    last_b_p0 <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    logic signed [RES_W-1:0] a_ext;
    logic signed [RES_W-1:0] b_ext;
    logic signed [RES_W-1:0] res_nxt;
    mode_t                   mode_nxt;

    assign a_ext = $signed({{(RES_W-DATA_W){1'b0}}, a_p0});
    assign b_ext = $signed({{(RES_W-DATA_W){1'b0}}, b_p0});

    // ALU: operands are non-negative, so signed division already floors.
    always_comb begin
        res_nxt  = '0;
        mode_nxt = MODE_NUM;
        case (bus.arif)
            4'b1110: res_nxt = a_ext + b_ext;
            4'b1101: res_nxt = a_ext - b_ext;
            4'b1011: res_nxt = a_ext * b_ext;
            4'b0111: begin
                if (b_p0 == '0) mode_nxt = MODE_ERR;
                else            res_nxt  = a_ext / b_ext;
            end
            4'b1111: res_nxt = last_b_p0 ? b_ext : a_ext;
            default: mode_nxt = MODE_DASH;
        endcase
    end

    // ---------------- stage p1: result register ----------------
    logic signed [RES_W-1:0] result_p1;
    mode_t                   mode_p1;

    // Result follows operands/op one clock later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_p1 <= '0;
            mode_p1   <= MODE_NUM;
        end else begin
            result_p1 <= res_nxt;
            mode_p1   <= mode_nxt;
        end
    end

    logic signed [RES_W-1:0] neg_res;
    logic [7:0]              mag;
    logic [11:0]             bcd;
    logic [6:0]              dig_seg [4];

    assign neg_res = -result_p1;
    assign mag     = result_p1[RES_W-1] ? neg_res[7:0] : result_p1[7:0];
    assign bcd     = to_bcd(mag);

    // Per-digit segment patterns for the current result.
    always_comb begin
        dig_seg[0] = SEG_BLANK;
        dig_seg[1] = SEG_BLANK;
        dig_seg[2] = SEG_BLANK;
        dig_seg[3] = SEG_BLANK;
        case (mode_p1)
            MODE_ERR: begin
                dig_seg[2] = SEG_E;
                dig_seg[1] = SEG_R;
                dig_seg[0] = SEG_R;
            end
            MODE_DASH: begin
                dig_seg[3] = SEG_DASH;
                dig_seg[2] = SEG_DASH;
                dig_seg[1] = SEG_DASH;
                dig_seg[0] = SEG_DASH;
            end
            default: begin
                dig_seg[3] = result_p1[RES_W-1] ? SEG_DASH : SEG_BLANK;
                dig_seg[2] = seg7(bcd[11:8]);
                dig_seg[1] = seg7(bcd[7:4]);
                dig_seg[0] = seg7(bcd[3:0]);
`ifdef CALC_LZB_EN
                if (bcd[11:8] == 4'd0) begin
                    dig_seg[2] = SEG_BLANK;
                    if (bcd[7:4] == 4'd0) dig_seg[1] = SEG_BLANK;
                end
`endif
            end
        endcase
    end

    // ---------------- stage p2: scan and output registers ----------------
    logic [SCAN_BITS-1:0] scan_cnt;
    logic [1:0]           sel;

    assign sel = scan_cnt[SCAN_BITS-1 -: 2];

    // Anodes and segments load together so a digit never shows its neighbour's pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt     <= '0;
            bus.anodes   <= 4'b1111;
            bus.segments <= 8'hFF;
        end else begin
            scan_cnt     <= scan_cnt + 1'b1;
            bus.anodes   <= ~(4'b0001 << sel);
            bus.segments <= {1'b1, dig_seg[sel]};
        end
    end

endmodule

// File: tb/tb_calc_alu_seg.sv
// Bench for calc_alu_seg with SCAN_BITS=4: directed operand/op vectors, a
// queue of expected display strings and a monitor that collects one scan of
// digits and compares each against the expected pattern.
module tb_calc_alu_seg;

    localparam int SCAN_BITS = 4;
`ifdef CALC_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    logic [31:0] exp_q[$];
    string       name_q[$];

    calc_alu_seg_if bus();

    calc_alu_seg #(.SCAN_BITS(SCAN_BITS), .DATA_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] char_seg(input byte c);
        logic [7:0] s;
        case (c)
            "0": s = 8'hC0;
            "1": s = 8'hF9;
            "2": s = 8'hA4;
            "3": s = 8'hB0;
            "4": s = 8'h99;
            "5": s = 8'h92;
            "6": s = 8'h82;
            "7": s = 8'hF8;
            "8": s = 8'h80;
            "9": s = 8'h90;
            "-": s = 8'hBF;
            "E": s = 8'h86;
            "r": s = 8'hAF;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    function automatic string pick(input string plain, input string lzb_s);
        return LZB ? lzb_s : plain;
    endfunction

    task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] req);
        n_cmp++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s got %b required %b", name, got, req);
        end
    endtask

    task automatic load(input logic [1:0] k, input logic [3:0] v);
        @(negedge clk);
        bus.in_number = v;
        bus.key       = k;
        @(negedge clk);
        bus.key       = 2'b11;
    endtask

    task automatic set_op(input logic [3:0] op);
        @(negedge clk);
        bus.arif = op;
    endtask

    // Let the result settle, queue the expected digits, wait for the monitor.
    task automatic expect_disp(input string name, input string s);
        logic [31:0] e;
        repeat (24) @(negedge clk);
        for (int d = 0; d < 4; d++) e[8*d +: 8] = char_seg(s[3-d]);
        name_q.push_back(name);
        exp_q.push_back(e);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s timeout: display scan not collected, required \"%s\"", name, s);
            exp_q.delete();
            name_q.delete();
        end
    endtask

    // Monitor: per lit digit, compare segments against the head expectation.
    initial begin
        logic [3:0]  seen;
        logic [31:0] e;
        logic [7:0]  req;
        int          d;
        seen = 4'h0;
        forever begin
            @(negedge clk);
            if (rst || exp_q.size() == 0) begin
                seen = 4'h0;
            end else begin
                case (bus.anodes)
                    4'b1110: d = 0;
                    4'b1101: d = 1;
                    4'b1011: d = 2;
                    4'b0111: d = 3;
                    default: d = -1;
                endcase
                if (d < 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL %s anodes got %b required exactly one low", name_q[0], bus.anodes);
                    seen = 4'hF;
                end else if (!seen[d]) begin
                    e   = exp_q[0];
                    req = e[8*d +: 8];
                    n_cmp++;
                    if (bus.segments !== req) begin
                        n_fail++;
                        $display("FAIL %s digit%0d segments got %b required %b",
                                 name_q[0], d, bus.segments, req);
                    end
                    seen[d] = 1'b1;
                end
                if (seen == 4'hF) begin
                    void'(exp_q.pop_front());
                    void'(name_q.pop_front());
                    seen = 4'h0;
                end
            end
        end
    end

    // Stimulus
    initial begin
        n_cmp         = 0;
        n_fail        = 0;
        rst           = 1'b0;
        bus.in_number = 4'd0;
        bus.arif      = 4'b1111;
        bus.key       = 2'b11;
        #3 rst = 1'b1;
        #1;
        check_val("reset_anodes", {4'h0, bus.anodes}, 8'h0F);
        check_val("reset_segments", bus.segments, 8'hFF);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Scan order after release: digit0 lit one clk later, 4 clk per digit.
        @(posedge clk); #1;
        check_val("scan_d0", {4'h0, bus.anodes}, 8'h0E);
        repeat (4) @(posedge clk); #1;
        check_val("scan_d1", {4'h0, bus.anodes}, 8'h0D);
        repeat (4) @(posedge clk); #1;
        check_val("scan_d2", {4'h0, bus.anodes}, 8'h0B);
        repeat (4) @(posedge clk); #1;
        check_val("scan_d3", {4'h0, bus.anodes}, 8'h07);

        expect_disp("idle_after_reset", pick(" 000", "   0"));

        load(2'b10, 4'd7);
        load(2'b01, 4'd5);
        set_op(4'b1110);
        expect_disp("add_7_5", pick(" 012", "  12"));

        // Asynchronous reset in the middle of a scan.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("midrun_anodes", {4'h0, bus.anodes}, 8'h0F);
        check_val("midrun_segments", bus.segments, 8'hFF);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        expect_disp("add_after_reset", pick(" 000", "   0"));

        load(2'b10, 4'd3);
        load(2'b01, 4'd9);
        set_op(4'b1101);
        expect_disp("sub_3_9", pick("-006", "-  6"));

        load(2'b10, 4'd0);
        load(2'b01, 4'd15);
        expect_disp("sub_0_15", pick("-015", "- 15"));

        load(2'b10, 4'd15);
        load(2'b01, 4'd15);
        set_op(4'b1011);
        expect_disp("mul_15_15", " 225");

        load(2'b01, 4'd4);
        set_op(4'b0111);
        expect_disp("div_15_4", pick(" 003", "   3"));

        load(2'b01, 4'd0);
        expect_disp("div_by_zero", " Err");

        set_op(4'b1100);
        expect_disp("bad_op", "----");

        @(negedge clk);
        bus.in_number = 4'd9;
        bus.key       = 2'b00;
        repeat (3) @(negedge clk);
        bus.key       = 2'b11;
        set_op(4'b1110);
        expect_disp("both_keys_ignored", pick(" 015", "  15"));

        load(2'b01, 4'd9);
        set_op(4'b1111);
        expect_disp("idle_last_b", pick(" 009", "   9"));

        load(2'b10, 4'd4);
        expect_disp("idle_last_a", pick(" 004", "   4"));

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
